// File: rtl/swchdata_wr_arb_if.sv
// Bundle of requester, memory write, free, descriptor and statistics signals for swchdata_wr_arb.
// No logic inside; latency is defined by the arbiter that drives the slave side.
// Flow control: per-requester valid/ready, descriptor valid/ready, free is a one-cycle pulse.
interface swchdata_wr_arb_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_sop;
  logic [NREQ-1:0]        req_eop;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [AWIDTH-1:0]      mem_waddr;
  logic [DWIDTH-1:0]      mem_wdata;
  logic                   mem_write;
  logic                   free_valid;
  logic [AWIDTH:0]        free_len;
  logic                   desc_valid;
  logic                   desc_ready;
  logic [2:0]             desc_port;
  logic [AWIDTH-1:0]      desc_addr;
  logic [AWIDTH:0]        desc_len;
  logic                   desc_trunc;
  logic [AWIDTH:0]        used_words;
  logic [NREQ*16-1:0]     pkt_cnt;
  logic [15:0]            trunc_cnt;

  // requesters, egress scheduler and memory model side
  modport master (
    output req_valid, req_sop, req_eop, req_data, free_valid, free_len, desc_ready,
    input  req_ready, mem_waddr, mem_wdata, mem_write, desc_valid, desc_port,
           desc_addr, desc_len, desc_trunc, used_words, pkt_cnt, trunc_cnt
  );

  // arbiter side
  modport slave (
    input  req_valid, req_sop, req_eop, req_data, free_valid, free_len, desc_ready,
    output req_ready, mem_waddr, mem_wdata, mem_write, desc_valid, desc_port,
           desc_addr, desc_len, desc_trunc, used_words, pkt_cnt, trunc_cnt
  );
endinterface

// File: rtl/swchdata_wr_arb.sv
// Packet-granular round-robin write arbiter and circular-buffer allocator for the switch data memory.
// Latency: grant 1 cycle after sop, memory write 1 cycle after accept, descriptor 1 cycle after eop.
// Backpressure: losers stall on req_ready=0; descriptor held until desc_ready. Optional SWCHDATA_ARB_STATS_EN adds counters.
module swchdata_wr_arb #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10,
  parameter int MAXPKT = 384
) (
  input logic             clk,
  input logic             rst,
  swchdata_wr_arb_if.slave bus
);

  localparam int DEPTH = 1 << AWIDTH;
  // a grant needs MAXPKT free words, i.e. occupancy no higher than this
  localparam logic [AWIDTH:0] SPACE_LIM = (AWIDTH+1)'(DEPTH - MAXPKT);
  localparam logic [AWIDTH:0] MAXLEN    = (AWIDTH+1)'(MAXPKT);

  typedef enum logic [1:0] {IDLE, XFER, DESC} state_t;

  state_t            state;
  logic [2:0]        gnt;
  logic [2:0]        last_gnt;
  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] start_addr;
  logic [AWIDTH:0]   len;
  logic              trunc;

  // requester vectors padded to 8 so a 3-bit index is always in range
  logic [7:0]        cand8;
  logic [7:0]        valid8;
  logic [7:0]        ready8;
  logic [7:0]        eop8;
  logic              found;
  logic [2:0]        pick;
  logic              accept;
  logic              wr_now;
  logic [DWIDTH-1:0] gnt_data;
  logic [AWIDTH+1:0] used_inc;
  logic [AWIDTH+1:0] used_sub;
  logic [AWIDTH:0]   used_next;

  assign cand8  = 8'(bus.req_valid & bus.req_sop);
  assign valid8 = 8'(bus.req_valid);
  assign ready8 = 8'(bus.req_ready);
  assign eop8   = 8'(bus.req_eop);

  // round-robin search for the first sop candidate after the last granted port
  always_comb begin : grant_search
    logic [3:0] sum;
    sum   = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_gnt} + 4'(k);
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      if (!found && cand8[sum[2:0]]) begin
        found = 1'b1;
        pick  = sum[2:0];
      end
    end
  end

  // word acceptance from the granted port and occupancy arithmetic with underflow clamp
  always_comb begin
    accept    = valid8[gnt] & ready8[gnt];
    wr_now    = accept && (len < MAXLEN);
    gnt_data  = bus.req_data[int'(gnt)*DWIDTH +: DWIDTH];
    used_inc  = {1'b0, bus.used_words} + (AWIDTH+2)'(wr_now);
    used_sub  = bus.free_valid ? {1'b0, bus.free_len} : '0;
    used_next = (used_inc >= used_sub) ? (AWIDTH+1)'(used_inc - used_sub) : '0;
  end

  // packet FSM with registered write path, ready, descriptor and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gnt            <= '0;
      last_gnt       <= 3'(NREQ-1);
      wptr           <= '0;
      start_addr     <= '0;
      len            <= '0;
      trunc          <= 1'b0;
      bus.req_ready  <= '0;
      bus.mem_write  <= 1'b0;
      bus.mem_waddr  <= '0;
      bus.mem_wdata  <= '0;
      bus.desc_valid <= 1'b0;
      bus.desc_port  <= '0;
      bus.desc_addr  <= '0;
      bus.desc_len   <= '0;
      bus.desc_trunc <= 1'b0;
      bus.used_words <= '0;
    end else begin
      bus.mem_write  <= wr_now;
      bus.used_words <= used_next;
      if (wr_now) begin
        bus.mem_waddr <= wptr;
        bus.mem_wdata <= gnt_data;
      end
      case (state)
        IDLE: begin
          if (found && bus.used_words <= SPACE_LIM) begin
            gnt           <= pick;
            start_addr    <= wptr;
            len           <= '0;
            trunc         <= 1'b0;
            bus.req_ready <= NREQ'(1) << pick;
            state         <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            if (len < MAXLEN) begin
              wptr <= wptr + 1'b1;
              len  <= len + 1'b1;
            end else begin
              trunc <= 1'b1;
            end
            if (eop8[gnt]) begin
              bus.req_ready  <= '0;
              bus.desc_valid <= 1'b1;
              bus.desc_port  <= gnt;
              bus.desc_addr  <= start_addr;
              bus.desc_len   <= (len < MAXLEN) ? len + 1'b1 : len;
              bus.desc_trunc <= trunc | (len >= MAXLEN);
              state          <= DESC;
            end
          end
        end
        DESC: begin
          if (bus.desc_ready) begin
            bus.desc_valid <= 1'b0;
            last_gnt       <= gnt;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SWCHDATA_ARB_STATS_EN
  // per-port descriptor and truncation counters, bumped on the descriptor handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pkt_cnt   <= '0;
      bus.trunc_cnt <= '0;
    end else if (bus.desc_valid && bus.desc_ready) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.desc_port == 3'(i)) bus.pkt_cnt[i*16 +: 16] <= bus.pkt_cnt[i*16 +: 16] + 16'd1;
      end
      if (bus.desc_trunc) bus.trunc_cnt <= bus.trunc_cnt + 16'd1;
    end
  end
`else
  assign bus.pkt_cnt   = '0;
  assign bus.trunc_cnt = '0;
`endif

endmodule
